// File: rtl/mc_main_controller.sv
// Main control FSM of the multi-cycle RV32I core. It steps the shared ALU, the memory port,
// the register file and the immediate generator through the fetch, decode, execute and writeback steps.
module mc_main_controller #(
  parameter int DW = 32,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [6:0]    op,
  input  logic [2:0]    funct3,
  input  logic          zero,
  input  logic          mem_ready,
  output logic          mem_valid,
  output logic          mem_write,
  output logic          adr_src,
  output logic          ir_write,
  output logic          pc_write,
  output logic          reg_write,
  output logic [1:0]    alu_src_a,
  output logic [1:0]    alu_src_b,
  output logic [1:0]    alu_op,
  output logic [1:0]    result_src,
  output logic [2:0]    imm_src,
  output logic          illegal,
  output logic [SW-1:0] state_o
);

  // Memory handshake: mem_valid is raised and held steady with mem_write/adr_src until the
  // cycle mem_ready is high; that cycle completes the access and the FSM moves on.

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // The datapath width does not change any control port.
  if (DW < 1) begin : g_dw_info
  end

  state_t state, next_state;
  logic   mv_raw, mw_raw, irw_raw, pcw_raw, rw_raw;
  logic [2:0] imm_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_TRAP) illegal <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    mv_raw     = 1'b0;
    mw_raw     = 1'b0;
    irw_raw    = 1'b0;
    pcw_raw    = 1'b0;
    rw_raw     = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    case (state)
      S_FETCH: begin
        mv_raw    = 1'b1;
        alu_src_b = 2'b10;
        if (mem_ready) begin
          irw_raw    = 1'b1;
          pcw_raw    = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECR;
          OP_ITYPE:          next_state = S_EXECI;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_LUI:            next_state = S_LUI;
          default:           next_state = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        next_state = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mv_raw  = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        rw_raw     = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        mv_raw  = 1'b1;
        mw_raw  = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) next_state = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b10;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = 2'b10;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        rw_raw     = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          pcw_raw    = (funct3 == 3'b000) ? zero : ~zero;
          next_state = S_FETCH;
        end else begin
          next_state = S_TRAP;
        end
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pcw_raw    = 1'b1;
        next_state = S_ALUWB;
      end
      S_LUI: begin
        // ALU adds the immediate to a zero A operand; the A select is a don't-care here.
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        rw_raw     = 1'b1;
        next_state = S_FETCH;
      end
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_FETCH;
    endcase
  end

  always_comb begin
    imm_raw = 3'b000;
    case (op)
      OP_STORE:  imm_raw = 3'b001;
      OP_BRANCH: imm_raw = 3'b010;
      OP_JAL:    imm_raw = 3'b011;
      OP_LUI:    imm_raw = 3'b100;
      default:   imm_raw = 3'b000;
    endcase
  end

  // Reset gates the strobes combinationally so an in-flight access is dropped at once.
  assign mem_valid = mv_raw  & ~rst;
  assign mem_write = mw_raw  & ~rst;
  assign ir_write  = irw_raw & ~rst;
  assign pc_write  = pcw_raw & ~rst;
  assign reg_write = rw_raw  & ~rst;
  assign imm_src   = rst ? 3'b000 : imm_raw;
  assign state_o   = SW'(state);

endmodule

// File: tb/tb_mc_main_controller.sv
// Bench for mc_main_controller: a table of instructions is expanded by a cycle model into
// expected per-cycle output words, queued, and compared as the DUT steps.
module tb_mc_main_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero, mem_ready;
  logic       mem_valid, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [2:0] imm_src;
  logic [3:0] state_o;

  mc_main_controller #(.DW(32), .SW(4)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .mem_valid(mem_valid), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .imm_src(imm_src), .illegal(illegal),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MB = 4'd4, MW = 4'd5;
  localparam logic [3:0] ER = 4'd6, EI = 4'd7, AW = 4'd8, BR = 4'd9, JL = 4'd10, LU = 4'd11;
  localparam logic [3:0] TR = 4'd15;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       zero;
    int         dly;
    logic [2:0] exp_imm;
  } vec_t;

  vec_t       vecs[14];
  logic [21:0] exp_q[$];
  logic        rdy_q[$];
  int          n_vec = 0;
  int          n_miss = 0;
  logic [2:0]  cur_f3, cur_imm;
  logic        cur_zero, trapped;

  // Word: {state, illegal, mv, mw, adr, irw, pcw, rw, srcA, srcB, aluop, result, imm}
  function automatic logic [21:0] model(input logic [3:0] st, input logic rdy, input logic ill);
    logic mv = 0, mw = 0, as = 0, irw = 0, pcw = 0, rw = 0;
    logic [1:0] sa = 0, sb = 0, ao = 0, rs = 0;
    case (st)
      F:  begin mv = 1; sb = 2'b10; irw = rdy; pcw = rdy; end
      D:  begin sa = 2'b01; sb = 2'b01; end
      MA: begin sa = 2'b10; sb = 2'b01; end
      MR: begin mv = 1; as = 1; end
      MB: begin rs = 2'b01; rw = 1; end
      MW: begin mv = 1; mw = 1; as = 1; end
      ER: begin sa = 2'b10; ao = 2'b10; end
      EI: begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
      AW: rw = 1;
      BR: begin
        sa = 2'b10; ao = 2'b01;
        pcw = (cur_f3 == 3'b000 && cur_zero) || (cur_f3 == 3'b001 && !cur_zero);
      end
      JL: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      LU: begin sb = 2'b01; rs = 2'b10; rw = 1; end
      default: ;
    endcase
    return {st, ill, mv, mw, as, irw, pcw, rw, sa, sb, ao, rs, cur_imm};
  endfunction

  function automatic logic [21:0] act_word();
    return {state_o, illegal, mem_valid, mem_write, adr_src, ir_write, pc_write, reg_write,
            alu_src_a, alu_src_b, alu_op, result_src, imm_src};
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy, input logic ill);
    exp_q.push_back(model(st, rdy, ill));
    rdy_q.push_back(rdy);
  endtask

  task automatic push_mem(input logic [3:0] st, input int dly);
    for (int i = 0; i < dly; i++) push(st, 1'b0, 1'b0);
    push(st, 1'b1, 1'b0);
  endtask

  // mem_ready is randomised where the FSM must ignore it.
  task automatic push_any(input logic [3:0] st);
    push(st, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic push_trap();
    push_any(TR);
    push(TR, 1'b1, 1'b1);
    push(TR, 1'b0, 1'b1);
    trapped = 1'b1;
  endtask

  task automatic build(input logic [6:0] o, input int dly);
    trapped = 1'b0;
    push_mem(F, dly);
    push_any(D);
    case (o)
      7'b0000011: begin push_any(MA); push_mem(MR, dly); push_any(MB); end
      7'b0100011: begin push_any(MA); push_mem(MW, dly); end
      7'b0110011: begin push_any(ER); push_any(AW); end
      7'b0010011: begin push_any(EI); push_any(AW); end
      7'b1100011: begin
        push_any(BR);
        if (cur_f3 != 3'b000 && cur_f3 != 3'b001) push_trap();
      end
      7'b1101111: begin push_any(JL); push_any(AW); end
      7'b0110111: push_any(LU);
      default:    push_trap();
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Each cycle starts 1 time unit after a rising edge; outputs are sampled on the falling edge.
  task automatic run_queue(input string name);
    logic [21:0] e, a;
    int cyc = 0;
    while (exp_q.size() > 0) begin
      mem_ready = rdy_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      a = act_word();
      if (e[21:18] == LU) begin
        a[10:9] = 2'b00;
        e[10:9] = 2'b00;
      end
      chk($sformatf("%s cycle %0d", name, cyc), 32'(a), 32'(e));
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("reset outputs", 32'(act_word()), 32'({F, 1'b0, 6'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000}));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{"lw_late",   7'b0000011, 3'b010, 1'b0, 1, 3'b000};
    vecs[1]  = '{"lw_fast",   7'b0000011, 3'b010, 1'b0, 0, 3'b000};
    vecs[2]  = '{"sw_fast",   7'b0100011, 3'b010, 1'b0, 0, 3'b001};
    vecs[3]  = '{"sw_slow",   7'b0100011, 3'b010, 1'b1, 2, 3'b001};
    vecs[4]  = '{"add",       7'b0110011, 3'b000, 1'b0, 0, 3'b000};
    vecs[5]  = '{"addi",      7'b0010011, 3'b000, 1'b1, 1, 3'b000};
    vecs[6]  = '{"beq_taken", 7'b1100011, 3'b000, 1'b1, 0, 3'b010};
    vecs[7]  = '{"beq_not",   7'b1100011, 3'b000, 1'b0, 0, 3'b010};
    vecs[8]  = '{"bne_taken", 7'b1100011, 3'b001, 1'b0, 0, 3'b010};
    vecs[9]  = '{"bne_not",   7'b1100011, 3'b001, 1'b1, 0, 3'b010};
    vecs[10] = '{"jal",       7'b1101111, 3'b000, 1'b0, 0, 3'b011};
    vecs[11] = '{"lui",       7'b0110111, 3'b000, 1'b0, 0, 3'b100};
    vecs[12] = '{"blt_trap",  7'b1100011, 3'b100, 1'b0, 0, 3'b010};
    vecs[13] = '{"ecall",     7'b1110011, 3'b000, 1'b0, 0, 3'b000};

    op = 7'b0; funct3 = 3'b0; zero = 1'b0; mem_ready = 1'b0;
    do_reset();

    for (int i = 0; i < 14; i++) begin
      op = vecs[i].op; funct3 = vecs[i].f3; zero = vecs[i].zero;
      cur_f3 = vecs[i].f3; cur_zero = vecs[i].zero; cur_imm = vecs[i].exp_imm;
      build(vecs[i].op, vecs[i].dly);
      run_queue(vecs[i].name);
      if (trapped) do_reset();
    end

    // Reset arriving while a load waits on memory must drop the request immediately.
    op = 7'b0000011; funct3 = 3'b010; zero = 1'b0;
    cur_f3 = 3'b010; cur_zero = 1'b0; cur_imm = 3'b000;
    push_mem(F, 0);
    push_any(D);
    push_any(MA);
    push(MR, 1'b0, 1'b0);
    run_queue("lw_abort");
    mem_ready = 1'b0;
    #2;
    chk("memread waiting", {27'b0, state_o, mem_valid}, {27'b0, MR, 1'b1});
    rst = 1'b1;
    #1;
    chk("abort in reset", {26'b0, state_o, mem_valid, ir_write}, {26'b0, F, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("fetch after abort", {27'b0, state_o, mem_valid}, {27'b0, F, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
